// File: rtl/tri_bus_arbiter.sv
// ============================================================================
// Module   : tri_bus_arbiter
// Purpose  : Round-robin owner selection for a shared tri-state bus, with an
//            all-released turnaround gap between successive owners.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tri_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [NUM_REQ-1:0]         o_drive_en,
    output logic [$clog2(NUM_REQ)-1:0] o_owner,
    output logic                       o_busy
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int TURN_W = $clog2(TURNAROUND + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [NUM_REQ-1:0]  drive_en_q;
    logic [IDX_W-1:0]    owner_q;
    logic [IDX_W-1:0]    rr_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [TURN_W-1:0]   turn_q;
    logic                busy_q;

    logic                win_vld;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W:0]      cand;
    logic [NUM_REQ-1:0]  win_oh;
    logic                others_pending;
    logic                owner_req;
    logic [IDX_W-1:0]    rr_next;

    // Scan downward so the closest set bit at or after the pointer is the last one written.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (i_req[cand[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign win_oh         = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
    assign others_pending = |(i_req & ~grant_q);
    assign owner_req      = i_req[owner_q];
    assign rr_next        = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    // The hold budget only runs while someone else is waiting, so a lone owner
    // that is later joined by a competitor still gets a full MAX_HOLD window.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            drive_en_q <= '0;
            owner_q    <= '0;
            rr_q       <= '0;
            hold_q     <= '0;
            turn_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_vld) begin
                        state_q    <= ST_GRANT;
                        grant_q    <= win_oh;
                        drive_en_q <= win_oh;
                        owner_q    <= win_idx;
                        hold_q     <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (!owner_req || (others_pending && hold_q >= HOLD_W'(MAX_HOLD - 1))) begin
                        state_q    <= ST_TURN;
                        grant_q    <= '0;
                        drive_en_q <= '0;
                        rr_q       <= rr_next;
                        hold_q     <= '0;
                        turn_q     <= '0;
                    end else if (others_pending) begin
                        if (hold_q != HOLD_W'(MAX_HOLD)) begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end else begin
                        hold_q <= '0;
                    end
                end
                ST_TURN: begin
                    if (turn_q == TURN_W'(TURNAROUND - 1)) begin
                        turn_q <= '0;
                        if (win_vld) begin
                            state_q    <= ST_GRANT;
                            grant_q    <= win_oh;
                            drive_en_q <= win_oh;
                            owner_q    <= win_idx;
                            hold_q     <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        turn_q <= turn_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    grant_q    <= '0;
                    drive_en_q <= '0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign o_grant    = grant_q;
    assign o_drive_en = drive_en_q;
    assign o_owner    = owner_q;
    assign o_busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_tri_bus_arbiter.sv
// ============================================================================
// Module   : tb_tri_bus_arbiter
// Purpose  : Directed and constrained-random checks of tri_bus_arbiter with
//            TURNAROUND=1 (dut A) and TURNAROUND=3 (dut B) sharing one request bus.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tri_bus_arbiter;

    localparam int STARVE_BOUND = 3 * (8 + 1) + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;

    logic [3:0] a_grant, a_en, b_grant, b_en;
    logic [1:0] a_owner, b_owner;
    logic       a_busy, b_busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    tri_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(8), .TURNAROUND(1)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .o_grant(a_grant), .o_drive_en(a_en), .o_owner(a_owner), .o_busy(a_busy)
    );

    tri_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(8), .TURNAROUND(3)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .o_grant(b_grant), .o_drive_en(b_en), .o_owner(b_owner), .o_busy(b_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 4'b0000;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Invariant monitor for the random phase; samples after the stimulus update.
    int         low_run [2];
    logic [3:0] prev_en [2];
    logic       seen    [2];
    int         wait_a  [4];

    always @(posedge clk) begin
        if (mon_en) begin
            #2;
            for (int d = 0; d < 2; d++) begin
                logic [3:0] en;
                int         t;
                en = (d == 0) ? a_en : b_en;
                t  = (d == 0) ? 1 : 3;
                check_eq(d == 0 ? "onehot0_a" : "onehot0_b", 32'($onehot0(en)), 32'd1);
                if (en != 4'b0 && prev_en[d] != 4'b0)
                    check_eq(d == 0 ? "en_stable_a" : "en_stable_b", 32'(en), 32'(prev_en[d]));
                if (en != 4'b0 && prev_en[d] == 4'b0 && seen[d])
                    check_eq(d == 0 ? "gap_a" : "gap_b", 32'(low_run[d] >= t), 32'd1);
                low_run[d] = (en == 4'b0) ? low_run[d] + 1 : 0;
                if (en != 4'b0) seen[d] = 1'b1;
                prev_en[d] = en;
            end
            check_eq("en_eq_grant_a", 32'(a_en), 32'(a_grant));
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !a_grant[i]) wait_a[i]++;
                else                       wait_a[i] = 0;
                check_eq("starve_a", 32'(wait_a[i] <= STARVE_BOUND), 32'd1);
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            low_run[d] = 0; prev_en[d] = 4'b0; seen[d] = 1'b0;
        end
        for (int i = 0; i < 4; i++) wait_a[i] = 0;

        // Reset state
        do_reset();
        check_eq("rst_grant", 32'(a_grant), 32'h0);
        check_eq("rst_en",    32'(a_en),    32'h0);
        check_eq("rst_owner", 32'(a_owner), 32'h0);
        check_eq("rst_busy",  32'(a_busy),  32'h0);

        // Reset mid-grant drops the enable before the next edge
        req = 4'b0010;
        step();
        check_eq("t1_grant", 32'(a_grant), 32'h2);
        check_eq("t1_owner", 32'(a_owner), 32'h1);
        step();
        step();
        rst = 1'b1;
        #1;
        check_eq("t1_async_en",    32'(a_en),    32'h0);
        check_eq("t1_async_grant", 32'(a_grant), 32'h0);
        step();
        rst = 1'b0;
        check_eq("t1_rel_en", 32'(a_en), 32'h0);
        step();
        check_eq("t1_regrant", 32'(a_grant), 32'h2);

        // Single short request: 3 grant cycles, one TURN, then IDLE
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("t2_grant", 32'(a_en),   32'h1);
            check_eq("t2_busy",  32'(a_busy), 32'h1);
        end
        req = 4'b0000;
        step();
        check_eq("t2_turn_en",   32'(a_en),   32'h0);
        check_eq("t2_turn_busy", 32'(a_busy), 32'h1);
        step();
        check_eq("t2_idle_en",   32'(a_en),    32'h0);
        check_eq("t2_idle_busy", 32'(a_busy),  32'h0);
        check_eq("t2_owner",     32'(a_owner), 32'h0);

        // All requesting: owners 0,1,2,3,0, eight cycles each plus one gap
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                check_eq("t3_en",    32'(a_en),    32'(1 << (k % 4)));
                check_eq("t3_owner", 32'(a_owner), 32'(k % 4));
            end
            step();
            check_eq("t3_gap", 32'(a_en), 32'h0);
        end

        // Lone owner keeps the bus, then is preempted after a full hold window
        do_reset();
        req = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            step();
            check_eq("t4_alone", 32'(a_en), 32'h8);
        end
        req = 4'b1001;
        for (int c = 0; c < 7; c++) begin
            step();
            check_eq("t4_hold", 32'(a_en), 32'h8);
        end
        step();
        check_eq("t4_turn", 32'(a_en), 32'h0);
        step();
        check_eq("t4_next",  32'(a_en),    32'h1);
        check_eq("t4_owner", 32'(a_owner), 32'h0);

        // Owner 3 releases: pointer wraps to 0; gap 1 on A, exactly 3 on B
        do_reset();
        req = 4'b1000;
        step();
        check_eq("t5_a_own3", 32'(a_en), 32'h8);
        check_eq("t5_b_own3", 32'(b_en), 32'h8);
        req = 4'b0001;
        step();
        check_eq("t5_a_turn", 32'(a_en), 32'h0);
        check_eq("t5_b_turn", 32'(b_en), 32'h0);
        step();
        check_eq("t5_a_wrap", 32'(a_en),    32'h1);
        check_eq("t5_a_own",  32'(a_owner), 32'h0);
        check_eq("t5_b_turn", 32'(b_en),    32'h0);
        step();
        check_eq("t5_b_turn",  32'(b_en),   32'h0);
        check_eq("t5_b_busy",  32'(b_busy), 32'h1);
        step();
        check_eq("t5_b_wrap", 32'(b_en),    32'h1);
        check_eq("t5_b_own",  32'(b_owner), 32'h0);

        // Non-owner drop during GRANT has no effect
        do_reset();
        req = 4'b0011;
        step();
        check_eq("t6_grant", 32'(a_en), 32'h1);
        req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            step();
            check_eq("t6_keep", 32'(a_en), 32'h1);
        end

        // Rotation after owner 1: pointer 2, so 3 beats 0; owner holds in IDLE
        do_reset();
        req = 4'b0010;
        step();
        req = 4'b0000;
        step();
        step();
        check_eq("t7_idle_busy",  32'(a_busy),  32'h0);
        check_eq("t7_idle_owner", 32'(a_owner), 32'h1);
        req = 4'b1001;
        step();
        check_eq("t7_rot_en",    32'(a_en),    32'h8);
        check_eq("t7_rot_owner", 32'(a_owner), 32'h3);

        // Random held requests with invariant monitor
        do_reset();
        mon_en = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(3) == 0) req[i] = 1'b1;
                end else if (a_grant[i]) begin
                    if ($urandom_range(7) == 0) req[i] = 1'b0;
                end
            end
            step();
        end
        mon_en = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
